// File: rtl/rtc_seg_pkg.sv
// rtc_seg_pkg
// Shared definitions for the 7-segment scan capture monitor.
//   - state_t     : per-select dwell states of the capture FSM
//   - NUM_DIGITS  : number of sampled digit positions (0..5)
//   - SEG_0..SEG_9: lit-segment patterns (g..a, active high) for each BCD digit
//   - seg_to_bcd  : maps an active-low g..a pattern to {err, nibble}
package rtc_seg_pkg;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  // The bus drives segments active-low, so the pattern is inverted before
  // matching. Anything that is not one of the ten digit shapes (including a
  // blanked digit) decodes to 4'hF with the error flag set.
  function automatic logic [4:0] seg_to_bcd(input logic [6:0] seg_n);
    logic [6:0] lit;
    logic [4:0] result;
    lit    = ~seg_n;
    result = {1'b1, 4'hF};
    case (lit)
      SEG_0:   result = {1'b0, 4'd0};
      SEG_1:   result = {1'b0, 4'd1};
      SEG_2:   result = {1'b0, 4'd2};
      SEG_3:   result = {1'b0, 4'd3};
      SEG_4:   result = {1'b0, 4'd4};
      SEG_5:   result = {1'b0, 4'd5};
      SEG_6:   result = {1'b0, 4'd6};
      SEG_7:   result = {1'b0, 4'd7};
      SEG_8:   result = {1'b0, 4'd8};
      SEG_9:   result = {1'b0, 4'd9};
      default: result = {1'b1, 4'hF};
    endcase
    return result;
  endfunction

endpackage

// File: rtl/rtc_seg_decode.sv
// rtc_seg_decode
// Purely combinational 7-segment to BCD decoder, reusable by any monitor
// that watches an active-low segment bus.
//   segments [7:0] in  : active-low segments, [7]=dp, [6:0]=g..a
//   nibble   [3:0] out : decoded BCD value, 4'hF when the pattern is illegal
//   err            out : high when the pattern matches no digit
module rtc_seg_decode
  import rtc_seg_pkg::*;
(
  input  logic [7:0] segments,
  output logic [3:0] nibble,
  output logic       err
);

  // The decimal point carries no digit information.
  logic dp_unused;
  assign dp_unused = segments[7];

  // Straight table lookup on g..a.
  always_comb begin
    {err, nibble} = seg_to_bcd(segments[6:0]);
  end

endmodule

// File: rtl/rtc_seg_capture.sv
// rtc_seg_capture
// Passive monitor on a multiplexed 7-segment display bus. Follows the digit
// scan, waits for each select to settle, decodes the segments back to BCD
// and commits a full 6-digit frame once every digit has been captured.
//   SETTLE_CYCLES  : cycles a select must be stable before sampling (>=1)
//   TIMEOUT_CYCLES : cycles without a commit before scan loss is flagged (>=2)
//   i_sys_clk           in  : system clock
//   i_reset_n           in  : asynchronous active-low reset
//   i_digits      [7:0] in  : digit select, active-low one-cold
//   i_segments    [7:0] in  : segments, active-low, [7]=dp, [6:0]=g..a
//   o_count      [23:0] out : last committed count, packed BCD, digit 0 in [3:0]
//   o_count_valid       out : one-cycle pulse when o_count updates
//   o_frame_err         out : one-cycle pulse when a frame completes with an
//                             illegal pattern
//   o_scan_lost         out : high while no commit for TIMEOUT_CYCLES cycles
module rtc_seg_capture
  import rtc_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        i_sys_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_digits,
  input  logic [7:0]  i_segments,
  output logic [23:0] o_count,
  output logic        o_count_valid,
  output logic        o_frame_err,
  output logic        o_scan_lost
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0]         SETTLE_TARGET = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0]         TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN      = '1;
  localparam logic [NUM_DIGITS-1:0] ONE_DIGIT     = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  // Registered copies of the bus; every decision below uses these.
  logic [7:0] digits_q;
  logic [7:0] last_digits;
  logic [7:0] segments_q;

  // Select qualification.
  logic [7:0] sel_n;
  logic       legal;
  logic [2:0] idx;
  logic       capturable;
  logic       changed;

  // Dwell FSM.
  state_t        state;
  state_t        state_next;
  logic [SW-1:0] settle_cnt;
  logic [SW-1:0] settle_next;
  logic          sample;
  logic          enter;

  // Frame assembly.
  logic [3:0]            dec_nibble;
  logic                  dec_err;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_next;
  logic                  frame_bad;
  logic                  frame_bad_next;
  logic [23:0]           buffer;
  logic                  commit;
  logic [TW-1:0]         idle_cnt;

  // Input registers. last_digits is one cycle behind digits_q so that a
  // select change is seen as a difference between the two.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      digits_q    <= 8'hFF;
      last_digits <= 8'hFF;
      segments_q  <= 8'hFF;
    end else begin
      digits_q    <= i_digits;
      last_digits <= digits_q;
      segments_q  <= i_segments;
    end
  end

  // A select is legal when exactly one bit is low. Digits 6 and 7 are legal
  // (they still end a dwell) but are never captured.
  always_comb begin
    sel_n      = ~digits_q;
    legal      = (sel_n != 8'h00) && ((sel_n & (sel_n - 8'd1)) == 8'h00);
    idx        = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (sel_n[k]) idx = 3'(k);
    end
    capturable = legal && (idx < 3'(NUM_DIGITS));
    changed    = (digits_q != last_digits);
  end

  rtc_seg_decode u_decode (
    .segments (segments_q),
    .nibble   (dec_nibble),
    .err      (dec_err)
  );

  // FSM state and settle counter.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= S_WAIT;
      settle_cnt <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
    end
  end

  // Next-state logic. A change while settling or holding is evaluated exactly
  // like a fresh select in S_WAIT in the same cycle, which also means a change
  // on the cycle the count would reach its target cancels that sample.
  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    sample      = 1'b0;
    enter       = 1'b0;

    case (state)
      S_WAIT: begin
        enter = 1'b1;
      end
      S_SETTLE: begin
        if (changed) begin
          enter = 1'b1;
        end else begin
          settle_next = settle_cnt + SW'(1);
          if (settle_next == SETTLE_TARGET) begin
            sample     = 1'b1;
            state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (changed) enter = 1'b1;
      end
      default: begin
        state_next  = S_WAIT;
        settle_next = '0;
      end
    endcase

    // With a one-cycle settle the load itself reaches the target.
    if (enter) begin
      if (capturable) begin
        settle_next = SW'(1);
        if (SETTLE_TARGET == SW'(1)) begin
          sample     = 1'b1;
          state_next = S_HOLD;
        end else begin
          state_next = S_SETTLE;
        end
      end else begin
        settle_next = '0;
        state_next  = S_WAIT;
      end
    end
  end

  // The commit uses the registered mask, so it fires on the edge after the
  // sixth distinct digit lands and always sees the just-sampled nibble.
  always_comb begin
    commit         = (seen == ALL_SEEN);
    seen_next      = commit ? '0 : seen;
    frame_bad_next = commit ? 1'b0 : frame_bad;
    if (sample) begin
      seen_next      = seen_next | (ONE_DIGIT << idx);
      frame_bad_next = frame_bad_next | dec_err;
    end
  end

  // Frame buffer, seen mask and outputs. The buffer is never cleared by a
  // commit; a re-sampled digit simply overwrites its slot.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      buffer        <= '0;
      seen          <= '0;
      frame_bad     <= 1'b0;
      o_count       <= '0;
      o_count_valid <= 1'b0;
      o_frame_err   <= 1'b0;
    end else begin
      if (sample) begin
        buffer[{idx, 2'b00} +: 4] <= dec_err ? 4'hF : dec_nibble;
      end
      seen          <= seen_next;
      frame_bad     <= frame_bad_next;
      o_count_valid <= commit && !frame_bad;
      o_frame_err   <= commit && frame_bad;
      if (commit && !frame_bad) o_count <= buffer;
    end
  end

  // Scan-health timer: any commit restarts it, otherwise it saturates.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idle_cnt <= '0;
    end else if (commit) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TIMEOUT_LIMIT) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign o_scan_lost = (idle_cnt == TIMEOUT_LIMIT);

endmodule

// File: tb/tb_rtc_seg_capture.sv
// tb_rtc_seg_capture
// Self-checking bench for rtc_seg_capture. A table of whole-frame scans is
// applied in a loop, followed by hand-written sequences for scan loss,
// illegal selects, reset mid-frame and re-sampled digits.
module tb_rtc_seg_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 200;

  logic        i_sys_clk;
  logic        i_reset_n;
  logic [7:0]  i_digits;
  logic [7:0]  i_segments;
  logic [23:0] o_count;
  logic        o_count_valid;
  logic        o_frame_err;
  logic        o_scan_lost;

  int checks;
  int failures;
  int cyc;
  int drive_cyc;
  int valid_pulses;
  int err_pulses;
  int valid_cyc;
  int base_valid;
  int base_err;
  logic lost_prev;
  logic lost_at_commit;
  logic lost_before_commit;

  typedef struct {
    string       name;
    logic [23:0] shown;
    logic [5:0]  blank;
    bit          dp;
    int          dwell;
    logic [23:0] exp_count;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t vecs [5];

  rtc_seg_capture #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .i_sys_clk     (i_sys_clk),
    .i_reset_n     (i_reset_n),
    .i_digits      (i_digits),
    .i_segments    (i_segments),
    .o_count       (o_count),
    .o_count_valid (o_count_valid),
    .o_frame_err   (o_frame_err),
    .o_scan_lost   (o_scan_lost)
  );

  initial i_sys_clk = 1'b0;
  always #5 i_sys_clk = ~i_sys_clk;

  initial cyc = 0;
  always @(posedge i_sys_clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the inactive edge.
  initial begin
    valid_pulses       = 0;
    err_pulses         = 0;
    valid_cyc          = 0;
    lost_prev          = 1'b0;
    lost_at_commit     = 1'b0;
    lost_before_commit = 1'b0;
  end
  always @(negedge i_sys_clk) begin
    if (o_count_valid === 1'b1) begin
      valid_pulses++;
      valid_cyc          = cyc;
      lost_at_commit     = o_scan_lost;
      lost_before_commit = lost_prev;
    end
    if (o_frame_err === 1'b1) err_pulses++;
    lost_prev = o_scan_lost;
  end

  function automatic vec_t mkVec(input string n, input logic [23:0] shown,
                                 input logic [5:0] blank, input bit dp,
                                 input int dwell, input logic [23:0] exp_count,
                                 input int exp_valid, input int exp_err);
    vec_t v;
    v.name      = n;
    v.shown     = shown;
    v.blank     = blank;
    v.dp        = dp;
    v.dwell     = dwell;
    v.exp_count = exp_count;
    v.exp_valid = exp_valid;
    v.exp_err   = exp_err;
    return v;
  endfunction

  // Active-low bus pattern for a digit value; dp lit when requested.
  function automatic logic [7:0] segOf(input logic [3:0] v, input bit dp);
    logic [6:0] lit;
    case (v)
      4'd0:    lit = 7'h3F;
      4'd1:    lit = 7'h06;
      4'd2:    lit = 7'h5B;
      4'd3:    lit = 7'h4F;
      4'd4:    lit = 7'h66;
      4'd5:    lit = 7'h6D;
      4'd6:    lit = 7'h7D;
      4'd7:    lit = 7'h07;
      4'd8:    lit = 7'h7F;
      4'd9:    lit = 7'h6F;
      default: lit = 7'h00;
    endcase
    return {~dp, ~lit};
  endfunction

  function automatic logic [7:0] selOf(input int k);
    logic [7:0] s;
    s = 8'd1 << k;
    return ~s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic showSelect(input logic [7:0] sel, input logic [7:0] seg,
                            input int dwell);
    i_digits   = sel;
    i_segments = seg;
    if (sel == 8'hDF) drive_cyc = cyc;
    repeat (dwell) @(negedge i_sys_clk);
  endtask

  task automatic showDigit(input int k, input logic [3:0] v, input int dwell);
    showSelect(selOf(k), segOf(v, 1'b0), dwell);
  endtask

  task automatic idle(input int n);
    showSelect(8'hFF, 8'hFF, n);
  endtask

  task automatic scanFrame(input logic [23:0] shown, input logic [5:0] blank,
                           input bit dp, input int dwell);
    logic [7:0] seg;
    for (int k = 0; k < 6; k++) begin
      seg = blank[k] ? 8'hFF : segOf(shown[4*k +: 4], dp);
      showSelect(selOf(k), seg, dwell);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    base_valid = valid_pulses;
    base_err   = err_pulses;
    scanFrame(v.shown, v.blank, v.dp, v.dwell);
    idle(6);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    drive_cyc  = 0;
    base_valid = 0;
    base_err   = 0;
    i_reset_n  = 1'b0;
    i_digits   = 8'hFF;
    i_segments = 8'hFF;

    vecs[0] = mkVec("frame_plain",   24'h654321, 6'b000000, 1'b0, 8, 24'h654321, 1, 0);
    vecs[1] = mkVec("frame_blank3",  24'h654321, 6'b001000, 1'b0, 8, 24'h654321, 0, 1);
    vecs[2] = mkVec("frame_dwell4",  24'h450789, 6'b000000, 1'b0, 4, 24'h450789, 1, 0);
    vecs[3] = mkVec("frame_dp",      24'h308642, 6'b000000, 1'b1, 5, 24'h308642, 1, 0);
    vecs[4] = mkVec("frame_dwell3",  24'h123456, 6'b000000, 1'b0, 3, 24'h308642, 0, 0);

    // Reset values.
    repeat (3) @(negedge i_sys_clk);
    #1;
    checkOutput("reset_count", 32'(o_count), 32'h0);
    checkOutput("reset_valid", 32'(o_count_valid), 32'h0);
    checkOutput("reset_err",   32'(o_frame_err), 32'h0);
    checkOutput("reset_lost",  32'(o_scan_lost), 32'h0);
    i_reset_n = 1'b1;
    @(negedge i_sys_clk);

    // Table of whole-frame scans.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput({vecs[i].name, "_valid"}, 32'(valid_pulses - base_valid), 32'(vecs[i].exp_valid));
      checkOutput({vecs[i].name, "_err"},   32'(err_pulses - base_err),     32'(vecs[i].exp_err));
      checkOutput({vecs[i].name, "_count"}, 32'(o_count),                   32'(vecs[i].exp_count));
    end

    // Scan loss, then a valid frame clears it on the commit edge.
    checkOutput("lost_before_expiry", 32'(o_scan_lost), 32'h0);
    idle(TIMEOUT + 10);
    #1;
    checkOutput("lost_after_expiry", 32'(o_scan_lost), 32'h1);
    base_valid = valid_pulses;
    scanFrame(24'h654321, 6'b0, 1'b0, 8);
    idle(6);
    #1;
    checkOutput("recover_valid",       32'(valid_pulses - base_valid), 32'h1);
    checkOutput("recover_count",       32'(o_count), 32'h654321);
    checkOutput("lost_cycle_before",   32'(lost_before_commit), 32'h1);
    checkOutput("lost_on_commit_edge", 32'(lost_at_commit), 32'h0);
    checkOutput("lost_after_commit",   32'(o_scan_lost), 32'h0);
    checkOutput("commit_latency",      32'(valid_cyc - drive_cyc), 32'(SETTLE + 2));

    // Illegal and unsampled selects interleaved with a valid scan.
    base_valid = valid_pulses;
    base_err   = err_pulses;
    showDigit(0, 4'd7, 8);
    showSelect(8'h00, segOf(4'd0, 1'b0), 8);
    showDigit(1, 4'd3, 8);
    showSelect(8'hFF, segOf(4'd0, 1'b0), 8);
    showDigit(2, 4'd9, 8);
    showSelect(8'hFC, segOf(4'd0, 1'b0), 8);
    showDigit(3, 4'd1, 8);
    showSelect(8'h7F, segOf(4'd0, 1'b0), 8);
    showDigit(4, 4'd2, 8);
    showDigit(5, 4'd8, 8);
    idle(6);
    #1;
    checkOutput("illegal_sel_valid", 32'(valid_pulses - base_valid), 32'h1);
    checkOutput("illegal_sel_err",   32'(err_pulses - base_err), 32'h0);
    checkOutput("illegal_sel_count", 32'(o_count), 32'h821937);

    // Reset after four of six digits, then a rotated scan.
    showDigit(0, 4'd5, 8);
    showDigit(1, 4'd5, 8);
    showDigit(2, 4'd5, 8);
    showDigit(3, 4'd5, 8);
    i_digits   = 8'hFF;
    i_segments = 8'hFF;
    #2 i_reset_n = 1'b0;
    #1;
    checkOutput("midreset_count", 32'(o_count), 32'h0);
    checkOutput("midreset_valid", 32'(o_count_valid), 32'h0);
    checkOutput("midreset_err",   32'(o_frame_err), 32'h0);
    checkOutput("midreset_lost",  32'(o_scan_lost), 32'h0);
    @(negedge i_sys_clk);
    i_reset_n  = 1'b1;
    base_valid = valid_pulses;
    showDigit(4, 4'd7, 8);
    showDigit(5, 4'd8, 8);
    showDigit(0, 4'd1, 8);
    showDigit(1, 4'd2, 8);
    showDigit(2, 4'd3, 8);
    idle(6);
    #1;
    checkOutput("rotated_no_early_commit", 32'(valid_pulses - base_valid), 32'h0);
    showDigit(3, 4'd4, 8);
    idle(6);
    #1;
    checkOutput("rotated_valid", 32'(valid_pulses - base_valid), 32'h1);
    checkOutput("rotated_count", 32'(o_count), 32'h874321);

    // Digit 2 captured twice within one frame; the later value wins.
    base_valid = valid_pulses;
    showDigit(0, 4'd3, 8);
    showDigit(1, 4'd1, 8);
    showDigit(2, 4'd7, 8);
    idle(4);
    showDigit(2, 4'd9, 8);
    showDigit(3, 4'd5, 8);
    showDigit(4, 4'd2, 8);
    showDigit(5, 4'd6, 8);
    idle(6);
    #1;
    checkOutput("resample_valid", 32'(valid_pulses - base_valid), 32'h1);
    checkOutput("resample_count", 32'(o_count), 32'h625913);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_seg_capture.md
# rtc_seg_capture

Passive monitor that attaches to the stopwatch's multiplexed 7‑segment display bus (digit select plus segment lines) and reconstructs the displayed 6‑digit BCD count. It is the receiving end of the display adapter's scan protocol. It tracks the digit scan, waits for each select to settle, decodes segment patterns back to BCD and commits a whole frame once all six digits have been captured. It is used for self‑check, test readback and scan‑health monitoring alongside the stopwatch core.

## Interface
- SETTLE_CYCLES, 4: consecutive cycles a digit select must be stable before its segments are sampled (≥1).
- TIMEOUT_CYCLES, 65536: cycles without a commit before scan loss is flagged (≥2).
- i_sys_clk  in  1  system clock; single clock domain.
- i_reset_n  in  1  asynchronous, active‑low reset.
- i_digits  in  8  digit select, active‑low one‑cold; bit k selects digit k.
- i_segments  in  8  segments, active‑low; [7]=dp, [6:0]=g..a.
- o_count  out  24  last committed count, packed BCD; [3:0]=digit 0 (least significant), [23:20]=digit 5.
- o_count_valid  out  1  one‑cycle pulse when o_count updates.
- o_frame_err  out  1  one‑cycle pulse when a frame completes with an illegal pattern.
- o_scan_lost  out  1  level; high while no commit has occurred for TIMEOUT_CYCLES cycles.

## Operation
- i_digits and i_segments are registered once on entry. All decisions use the registered copies.
- A select is legal when exactly one bit is low. All‑high (blank) and multi‑low selects are ignored. Digits 6 and 7 are legal but never sampled.
- FSM per select dwell:
  - S_WAIT: on a legal select for digits 0–5, go to S_SETTLE and load settle counter = 1.
  - S_SETTLE: if the select is unchanged, increment. When the counter reaches SETTLE_CYCLES, sample and go to S_HOLD. On any select change, return to S_WAIT; the new select is evaluated in the same cycle.
  - S_HOLD: take no further samples. On a select change, evaluate as in S_WAIT.
- Each digit is sampled exactly once per dwell.
- Decode: invert segments, ignore dp, then match g..a against 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A match writes its BCD nibble into the frame buffer slot for that digit.
  - No match writes 4'hF and sets the frame's error bit.
- A 6‑bit seen mask sets the bit for each sampled digit. A re‑sample of an already‑seen digit overwrites its nibble; the mask is unchanged.
- Commit happens when the mask equals 6'h3F:
  - Error bit clear: o_count ← buffer and pulse o_count_valid.
  - Error bit set: o_count is held and o_frame_err pulses.
  - In either case, clear the mask and the error bit. The buffer is not cleared.
- Timeout counter: cleared on every commit (valid or error), saturates at TIMEOUT_CYCLES. o_scan_lost = (counter == TIMEOUT_CYCLES).

## Timing
- Reset values: o_count=0, o_count_valid=0, o_frame_err=0, o_scan_lost=0, FSM=S_WAIT, mask=0, all counters=0.
- Latency:
  - Pin‑to‑register: 1 cycle.
  - Sample: on the edge where the settle count reaches SETTLE_CYCLES, i.e. SETTLE_CYCLES edges after the registered select first shows the new value.
  - Commit: o_count, o_count_valid and o_frame_err update on the edge after the sixth distinct digit is sampled.
- Sample and commit in the same cycle: never coincide for the same digit; the commit uses the buffer including the just‑sampled nibble.
- A select change on the same edge the settle count would reach SETTLE_CYCLES cancels the sample.
- Dwell shorter than SETTLE_CYCLES: the digit is never captured and the frame does not complete (visible only through o_scan_lost).
- Timeout and commit on the same edge: the commit wins; o_scan_lost deasserts on that edge.
- Async reset mid‑frame clears all state immediately. The first commit after reset requires all six digits again.

## Structure
- Package rtc_seg_pkg holds:
  - The state enum (S_WAIT, S_SETTLE, S_HOLD).
  - The ten segment pattern constants.
  - NUM_DIGITS=6.
  - A function seg_to_bcd returning {err, nibble}.
- A sub‑module rtc_seg_decode is natural: a purely combinational pattern‑to‑BCD decoder, reusable by other monitors.
- Counter widths: $clog2(SETTLE_CYCLES+1) and $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Scan digits 0–5 showing 1,2,3,4,5,6 (digit 0=1), dwell 8 cycles each → one o_count_valid pulse, o_count=24'h654321, o_frame_err=0.
- Same scan, but digit 3 segments = 8'hFF (blank) → o_frame_err pulses once, o_count keeps its prior value, o_count_valid stays low.
- Dwell of 3 cycles with SETTLE_CYCLES=4 → no sample, no commit. After TIMEOUT_CYCLES cycles o_scan_lost=1; a following valid 8‑cycle scan commits and clears it on the same edge.
- Selects 8'h00, 8'hFF and 8'hFC interleaved with a valid scan → ignored; the commit value is unaffected.
- Assert i_reset_n low after 4 of 6 digits → outputs return to 0 immediately. Then scan digits 4,5,0,1,2,3 → a single commit after digit 3.
- Digit 2 re‑sampled with 7 then 9 before the frame completes → the committed nibble for digit 2 is 9.
